apb_master_ctrl: RTL and testbench
==================================

// Module: apb_master_ctrl
// PURPOSE
// - APB initiator for the AHB2APB bridge. Accepts one request at a time on a
//   valid/ready port and decodes the address to one of 3 slave selects.
// - Runs the APB SETUP->ACCESS sequence, waits on pready and returns prdata
//   and an error flag on a one-cycle response strobe.
// - Drives pselx/penable/pwrite/paddr/pwdata into the APB slave-side interface.
// - Receives prdata back from that same interface.
// PARAMETERS
// - TIMEOUT_CYCLES  16  max ACCESS cycles with pready=0 before abort (>=1)
// - CNT_W           5   width of wait counter; must hold TIMEOUT_CYCLES
// PORTS
// - hclk       in   1   single clock, all logic rising-edge
// - hreset     in   1   synchronous, active-high reset
// - req_valid  in   1   request present
// - req_ready  out  1   controller idle, request accepted when valid&ready
// - req_write  in   1   1=write, 0=read
// - req_addr   in   32  byte address
// - req_wdata  in   32  write data
// - rsp_valid  out  1   one-cycle completion strobe
// - rsp_rdata  out  32  read data (0 for writes/errors)
// - rsp_err    out  1   pslverr, timeout or unmapped address
// - pselx      out  3   one-hot slave select
// - penable    out  1   APB enable (ACCESS phase)
// - pwrite     out  1   APB direction
// - paddr      out  32  APB address
// - pwdata     out  32  APB write data
// - prdata     in   32  APB read data
// - pready     in   1   slave ready; tie 1 for zero-wait slaves
// - pslverr    in   1   slave error, sampled with pready
// BEHAVIOUR
// - Reset (hreset=1 at edge):
//   - state=IDLE; pselx, penable, pwrite, paddr, pwdata = 0.
//   - rsp_valid, rsp_rdata, rsp_err = 0; wait counter = 0.
//   - Any in-flight transfer is dropped with no response.
// - States: IDLE, SETUP, ACCESS. All outputs are registered except req_ready.
// - req_ready = (state==IDLE) & ~hreset.
// - IDLE, accepting a request: latch addr, wdata and write; decode the address.
//   - Mapped address: -> SETUP. pselx=decode, penable=0.
//   - Unmapped address: stay IDLE, no APB activity. Next cycle rsp_valid=1,
//     rsp_err=1, rsp_rdata=0.
// - Address map (decode on req_addr[31:24]):
//   - 0x80 -> 3'b001
//   - 0x84 -> 3'b010
//   - 0x88 -> 3'b100
//   - anything else unmapped.
// - SETUP: one cycle only -> ACCESS, penable=1, wait counter cleared.
// - ACCESS with pready=1: transfer completes.
//   - pselx=0, penable=0, -> IDLE.
//   - Next cycle: rsp_valid=1, rsp_err=pslverr.
//   - rsp_rdata = prdata for reads with pslverr=0; 0 otherwise.
// - ACCESS with pready=0: increment the counter and hold every APB output stable.
//   - Counter reaching TIMEOUT_CYCLES: abort. pselx=0, penable=0, -> IDLE.
//   - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
// - Latency, zero-wait slave: accept at cycle 0, SETUP at 1, ACCESS at 2,
//   rsp_valid at 3, next accept at 3.
// - Minimum spacing between transfers is 3 cycles.
// - paddr, pwrite and pwdata keep their last values after a transfer.
// - rsp_valid always asserts exactly one cycle per accepted request; no rsp
//   without a request.
// - pready/pslverr are ignored outside ACCESS.
// STRUCTURE
// - ahb2apb_pkg holds:
//   - state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2)
//   - slave base bytes 8'h80/8'h84/8'h88 and the PSEL one-hot constants.
// - Sub-module apb_addr_decode: combinational, addr[31:24] -> {psel[2:0], hit}.
// TESTING
// - Write, addr 0x8000_0010, wdata 0xDEAD_BEEF, pready=1:
//   - pselx=001 from cycle 1, penable=1 at cycle 2, pwrite=1.
//   - rsp_valid at 3 with err=0.
// - Read, addr 0x8400_0004, slave prdata=0x19, pready low 2 cycles:
//   - ACCESS held 3 cycles with all APB outputs stable.
//   - rsp_rdata=0x19, err=0.
// - Read, addr 0x8800_0000, pready low forever:
//   - abort after 16 wait cycles, pselx=0.
//   - rsp_err=1, rsp_rdata=0.
// - Addr 0x9000_0000:
//   - pselx stays 0.
//   - rsp_valid the cycle after accept with err=1.
// - Read with pslverr=1 on the pready cycle: rsp_err=1, rsp_rdata=0.
// - hreset asserted during ACCESS:
//   - next edge pselx=0, penable=0, req_ready=1.
//   - no rsp_valid.

Source files
------------

// File: rtl/ahb2apb_pkg.sv
// Shared definitions for the AHB2APB bridge APB initiator: FSM encoding,
// slave base bytes and the one-hot PSEL patterns they map to.
package ahb2apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam logic [7:0] SLV0_BASE = 8'h80;
    localparam logic [7:0] SLV1_BASE = 8'h84;
    localparam logic [7:0] SLV2_BASE = 8'h88;

    localparam logic [2:0] PSEL_NONE = 3'b000;
    localparam logic [2:0] PSEL_S0   = 3'b001;
    localparam logic [2:0] PSEL_S1   = 3'b010;
    localparam logic [2:0] PSEL_S2   = 3'b100;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder: top address byte -> one-hot slave select
// plus a hit flag for mapped regions.
module apb_addr_decode
    import ahb2apb_pkg::*;
(
    input  logic [7:0] i_addr_msb,
    output logic [2:0] o_psel,
    output logic       o_hit
);

    always_comb begin
        // NOTE: default assignment first so every path drives o_psel and no latch is inferred.
        o_psel = PSEL_NONE;
        case (i_addr_msb)
            SLV0_BASE: o_psel = PSEL_S0;
            SLV1_BASE: o_psel = PSEL_S1;
            SLV2_BASE: o_psel = PSEL_S2;
            default:   o_psel = PSEL_NONE;
        endcase
        o_hit = |o_psel;
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB initiator: accepts one request at a time, runs SETUP->ACCESS with a
// bounded pready wait, and returns a one-cycle response strobe.
module apb_master_ctrl
    import ahb2apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [2:0]  pselx,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    apb_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [2:0]       w_psel;
    logic             w_hit;

    apb_addr_decode u_decode (
        .i_addr_msb (req_addr[31:24]),
        .o_psel     (w_psel),
        .o_hit      (w_hit)
    );

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign req_ready = (r_state == ST_IDLE) & ~hreset;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            pselx     <= PSEL_NONE;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        paddr  <= req_addr;
                        pwrite <= req_write;
                        pwdata <= req_wdata;
                        if (w_hit) begin
                            pselx   <= w_psel;
                            penable <= 1'b0;
                            r_state <= ST_SETUP;
                        end else begin
                            // Unmapped: answer immediately without touching the APB bus.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                ST_SETUP: begin
                    penable <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        pselx     <= PSEL_NONE;
                        penable   <= 1'b0;
                        r_state   <= ST_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= pslverr;
                        rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
                    end else if (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                        pselx     <= PSEL_NONE;
                        penable   <= 1'b0;
                        r_state   <= ST_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: table of transfers driven through a
// small slave model, responses scored against a queue of expected results.
module tb_apb_master_ctrl;

    localparam int TIMEOUT = 16;
    localparam int FOREVER = 1000;

    logic        hclk;
    logic        hreset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [2:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    apb_master_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(5)) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .pselx     (pselx),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        pslverr;
        int          waits;       // ACCESS cycles with pready low
        logic [2:0]  exp_psel;
        int          exp_cycles;  // expected ACCESS length
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t sb_q[$];
    vec_t vecs[9];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_rsp    = 0;
    int   n_req    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // NOTE: outputs are sampled on the falling edge, well away from the rising edge that updates them.
    task automatic tick();
        rsp_t e;
        @(negedge hclk);
        if (rsp_valid === 1'b1) begin
            n_rsp++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: rsp_valid=1 with no outstanding request (t=%0t)", $time);
            end else begin
                e = sb_q.pop_front();
                check("rsp_err", rsp_err, e.err);
                check("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input logic se, input int waits,
                                input logic [2:0] ps, input int cyc, input logic err,
                                input logic [31:0] rdata);
        vec_t v;
        v.write = w;  v.addr = a;  v.wdata = wd;  v.prdata = rd;  v.pslverr = se;
        v.waits = waits;  v.exp_psel = ps;  v.exp_cycles = cyc;
        v.exp_err = err;  v.exp_rdata = rdata;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int guard = 0;
        int j;
        int rsp0;
        while (req_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        prdata    = v.prdata;
        // Slave strobes asserted outside ACCESS must be ignored.
        pready    = 1'b1;
        pslverr   = 1'b1;
        sb_q.push_back('{err: v.exp_err, rdata: v.exp_rdata});
        n_req++;
        rsp0 = n_rsp;
        tick();
        req_valid = 1'b0;
        check("pselx_after_accept", pselx, v.exp_psel);
        check("penable_after_accept", penable, 0);
        if (v.exp_psel == 3'b000) begin
            check("unmapped_rsp_next_cycle", n_rsp, rsp0 + 1);
            check("req_ready_after_unmapped", req_ready, 1);
        end else begin
            check("req_ready_setup", req_ready, 0);
            check("paddr_setup", paddr, v.addr);
            check("pwrite_setup", pwrite, v.write);
            check("pwdata_setup", pwdata, v.wdata);
            tick();
            j = 1;
            while (j < 40) begin
                check("penable_access", penable, 1);
                check("pselx_access", pselx, v.exp_psel);
                check("paddr_access", paddr, v.addr);
                check("pwrite_access", pwrite, v.write);
                check("pwdata_access", pwdata, v.wdata);
                pready  = (j > v.waits);
                pslverr = v.pslverr;
                tick();
                if (penable !== 1'b1) break;
                j++;
            end
            check("access_cycles", j, v.exp_cycles);
            check("pselx_after_done", pselx, 0);
            check("req_ready_after_done", req_ready, 1);
            check("rsp_latency", n_rsp, rsp0 + 1);
            check("paddr_held", paddr, v.addr);
            pready  = 1'b0;
            pslverr = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rsp_before;
        hreset    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        repeat (3) tick();
        check("reset_pselx", pselx, 0);
        check("reset_penable", penable, 0);
        check("reset_paddr", paddr, 0);
        check("reset_pwdata", pwdata, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_req_ready", req_ready, 0);
        hreset = 1'b0;
        #1;
        check("req_ready_after_reset", req_ready, 1);

        //           wr    addr          wdata         prdata        err  waits    psel    cyc      rsp_err rsp_rdata
        vecs[0] = mk(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 0,       3'b001, 1,       1'b0, 32'h0);
        vecs[1] = mk(1'b0, 32'h8400_0004, 32'h1111_2222, 32'h0000_0019, 1'b0, 2,       3'b010, 3,       1'b0, 32'h19);
        vecs[2] = mk(1'b0, 32'h8800_0000, 32'h0,         32'h5555_AAAA, 1'b0, FOREVER, 3'b100, TIMEOUT, 1'b1, 32'h0);
        vecs[3] = mk(1'b1, 32'h9000_0000, 32'h0BAD_0BAD, 32'h7777_7777, 1'b0, 0,       3'b000, 0,       1'b1, 32'h0);
        vecs[4] = mk(1'b0, 32'h8000_0100, 32'h0,         32'hCAFE_F00D, 1'b1, 1,       3'b001, 2,       1'b1, 32'h0);
        vecs[5] = mk(1'b0, 32'h8800_00FC, 32'h0,         32'hA5A5_0001, 1'b0, 0,       3'b100, 1,       1'b0, 32'hA5A5_0001);
        vecs[6] = mk(1'b1, 32'h8400_0008, 32'h1357_9BDF, 32'hFFFF_FFFF, 1'b1, 3,       3'b010, 4,       1'b1, 32'h0);
        vecs[7] = mk(1'b0, 32'h7F00_0000, 32'h0,         32'h1234_5678, 1'b0, 0,       3'b000, 0,       1'b1, 32'h0);
        vecs[8] = mk(1'b0, 32'h8000_0000, 32'h0,         32'h0BAD_CAFE, 1'b0, 15,      3'b001, 16,      1'b0, 32'h0BAD_CAFE);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during ACCESS: bus drops, no response is produced.
        tick();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h8400_0020;
        tick();
        req_valid = 1'b0;
        pready    = 1'b0;
        tick();
        check("rst_seq_in_access", penable, 1);
        tick();
        rsp_before = n_rsp;
        hreset = 1'b1;
        @(posedge hclk);
        #1 hreset = 1'b0;
        tick();
        check("rst_seq_pselx", pselx, 0);
        check("rst_seq_penable", penable, 0);
        check("rst_seq_req_ready", req_ready, 1);
        check("rst_seq_rsp_valid", rsp_valid, 0);
        repeat (4) tick();
        check("rst_seq_no_rsp", n_rsp, rsp_before);

        // Recovery after the mid-transfer reset.
        run_vec(vecs[5]);
        repeat (3) tick();
        check("rsp_count_total", n_rsp, n_req);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
